// File: rtl/dmux_seq_ctrl_pkg.sv
// dmux_pkg: shared types, mode constants and lane helper for the demux sequencer
package dmux_pkg;
  typedef logic [1:0] lane_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;
  function automatic lane_t lane_next(input lane_t l);
    return l + 2'd1;
  endfunction
endpackage

// File: rtl/dmux_seq_ctrl_if.sv
// dmux_seq_ctrl_if: serial input handshake plus registered demux drive
interface dmux_seq_ctrl_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic y;
  logic s0;
  logic s1;
  logic y_valid;
  modport master(output in_valid, in_bit, input in_ready, y, s0, s1, y_valid);
  modport slave(input in_valid, in_bit, output in_ready, y, s0, s1, y_valid);
endinterface

// File: rtl/dmux_seq_ctrl_beat_counter.sv
// dmux_beat_counter: position within a burst, wrapping after BURST beats
module dmux_beat_counter #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       wrap
);
  logic [3:0] cnt_q, cnt_d;
  assign cnt  = cnt_q;
  assign wrap = cnt_q == 4'(BURST - 1);
  // clear wins over increment; the last beat rolls back to zero
  always_comb begin
    cnt_d = clr ? 4'd0 : inc ? (wrap ? 4'd0 : cnt_q + 4'd1) : cnt_q;
  end
  // beat register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dmux_seq_ctrl.sv
// dmux_seq_ctrl: groups a serial bit stream into per-lane bursts for a 1-to-4 demux
module dmux_seq_ctrl
  import dmux_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  input  logic             mode,
  input  lane_t            dir_lane,
  input  logic             stall,
  dmux_seq_ctrl_if.slave   bus,
  output lane_t            lane_idx,
  output logic             burst_done,
  output logic [CNT_W-1:0] tx_count
);
  state_t           state_q, state_d;
  lane_t            lane_q, lane_d, act;
  logic             y_q, y_d, s0_q, s0_d, s1_q, s1_d, yv_q, yv_d, bd_q, bd_d;
  logic [CNT_W-1:0] tx_q, tx_d;
  logic [3:0]       beat;
  logic             wrap, xfer, hold;
  assign bus.in_ready = enable & ~stall & ~flush & ~rst;
  assign xfer         = bus.in_valid & bus.in_ready;
  assign hold         = stall & ~flush;
  assign bus.y        = y_q;
  assign bus.s0       = s0_q;
  assign bus.s1       = s1_q;
  assign bus.y_valid  = yv_q;
  assign lane_idx     = {s0_q, s1_q};
  assign burst_done   = bd_q;
  assign tx_count     = tx_q;
  dmux_beat_counter #(.BURST(BURST)) u_beat (
    .clk (clk),
    .rst (rst),
    .inc (xfer),
    .clr (flush),
    .cnt (beat),
    .wrap(wrap)
  );
  // run-state tracking: leaving IDLE always passes through RUN first
  always_comb begin
    state_d = !enable ? IDLE : (state_q == IDLE || !stall) ? RUN : HOLD;
  end
  // lane choice: directed lane only sampled at a burst start, so mode changes apply at boundaries
  always_comb begin
    act    = (mode == MODE_DIR && beat == 4'd0) ? dir_lane : lane_q;
    lane_d = flush ? 2'd0 : (xfer && wrap) ? lane_next(act) : xfer ? act : lane_q;
  end
  // demux drive: stall freezes everything, idle cycles force y low so no output toggles
  always_comb begin
    y_d          = hold ? y_q : xfer & bus.in_bit;
    yv_d         = hold ? yv_q : xfer;
    bd_d         = hold ? bd_q : xfer & wrap;
    {s0_d, s1_d} = flush ? 2'b00 : xfer ? act : {s0_q, s1_q};
    tx_d         = xfer ? tx_q + CNT_W'(1) : tx_q;
  end
  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
      y_q     <= 1'b0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      yv_q    <= 1'b0;
      bd_q    <= 1'b0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      y_q     <= y_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      yv_q    <= yv_d;
      bd_q    <= bd_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: tb/tb_dmux_seq_ctrl.sv
// tb_dmux_seq_ctrl: directed checks of burst grouping, lane choice, stall, flush, reset and wrap
module tb_dmux_seq_ctrl;
  import dmux_pkg::*;
  logic       clk = 1'b0;
  logic       rst, enable, flush, mode, stall, in_valid, in_bit;
  lane_t      dir_lane, lane_a, lane_b;
  logic       bd_a, bd_b;
  logic [7:0] tx_a, tx_b;
  int         total = 0;
  int         bad = 0;
  int         rr_bits[9] = '{1, 0, 1, 1, 0, 0, 1, 0, 1};
  int         rr_lane[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int         rr_bd[9]   = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  int         dir_bits[4] = '{1, 1, 0, 1};
  dmux_seq_ctrl_if ia();
  dmux_seq_ctrl_if ib();
  assign ia.in_valid = in_valid;
  assign ia.in_bit   = in_bit;
  assign ib.in_valid = in_valid;
  assign ib.in_bit   = in_bit;
  dmux_seq_ctrl #(.BURST(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .mode(mode),
    .dir_lane(dir_lane), .stall(stall), .bus(ia.slave),
    .lane_idx(lane_a), .burst_done(bd_a), .tx_count(tx_a)
  );
  dmux_seq_ctrl #(.BURST(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .mode(mode),
    .dir_lane(dir_lane), .stall(stall), .bus(ib.slave),
    .lane_idx(lane_b), .burst_done(bd_b), .tx_count(tx_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; mode = 1'b0; stall = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; dir_lane = 2'd0;
    #1;
    chk("rst_y", ib.y, 0);
    chk("rst_lane", lane_b, 0);
    chk("rst_yv", ib.y_valid, 0);
    chk("rst_bd", bd_b, 0);
    chk("rst_tx", tx_b, 0);
    chk("rst_rdy", ib.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rdy_off", ib.in_ready, 0);
    enable = 1'b1;
    #1 chk("rdy_on", ib.in_ready, 1);
    for (int i = 0; i < 9; i++) begin
      send(1'b1, rr_bits[i][0]);
      chk($sformatf("rr_y%0d", i), ia.y, rr_bits[i]);
      chk($sformatf("rr_lane%0d", i), {ia.s0, ia.s1}, rr_lane[i]);
      chk($sformatf("rr_idx%0d", i), lane_a, rr_lane[i]);
      chk($sformatf("rr_bd%0d", i), bd_a, rr_bd[i]);
      chk($sformatf("rr_yv%0d", i), ia.y_valid, 1);
    end
    send(1'b0, 1'b1);
    chk("idle_y", ia.y, 0);
    chk("idle_yv", ia.y_valid, 0);
    chk("idle_lane", lane_a, 0);
    chk("rr_tx", tx_a, 9);
    flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    #1 chk("fl1_rdy", ib.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("fl1_yv", ib.y_valid, 0);
    chk("fl1_y", ib.y, 0);
    chk("fl1_lane", lane_b, 0);
    chk("fl1_tx", tx_b, 9);
    mode = 1'b1; dir_lane = 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) dir_lane = 2'b01;
      send(1'b1, dir_bits[i][0]);
      chk($sformatf("dir_y%0d", i), ib.y, dir_bits[i]);
      chk($sformatf("dir_lane%0d", i), lane_b, 2);
      chk($sformatf("dir_bd%0d", i), bd_b, i == 3 ? 1 : 0);
    end
    send(1'b1, 1'b1);
    chk("dir_next_lane", lane_b, 1);
    chk("dir_next_bd", bd_b, 0);
    chk("dir_tx", tx_b, 14);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_y", ib.y, 0);
    chk("arst_lane", lane_b, 0);
    chk("arst_yv", ib.y_valid, 0);
    chk("arst_tx", tx_b, 0);
    @(negedge clk);
    rst = 1'b0; mode = 1'b0;
    send(1'b1, 1'b1);
    chk("post_rst_lane", lane_b, 0);
    chk("post_rst_tx", tx_b, 1);
    send(1'b1, 1'b1);
    stall = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("st_rdy%0d", k), ib.in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("st_y%0d", k), ib.y, 1);
      chk($sformatf("st_yv%0d", k), ib.y_valid, 1);
      chk($sformatf("st_tx%0d", k), tx_b, 2);
    end
    stall = 1'b0;
    send(1'b1, 1'b0);
    chk("st_res_y", ib.y, 0);
    chk("st_res_yv", ib.y_valid, 1);
    chk("st_res_lane", lane_b, 0);
    chk("st_res_tx", tx_b, 3);
    send(1'b1, 1'b1);
    chk("b4_bd", bd_b, 1);
    mode = 1'b1; dir_lane = 2'b11;
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    chk("pre_fl_lane", lane_b, 3);
    chk("pre_fl_tx", tx_b, 6);
    flush = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    #1 chk("fl2_rdy", ib.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; mode = 1'b0;
    chk("fl2_yv", ib.y_valid, 0);
    chk("fl2_y", ib.y, 0);
    chk("fl2_lane", lane_b, 0);
    chk("fl2_tx", tx_b, 6);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1);
      chk($sformatf("fl2_b%0d_lane", i), lane_b, 0);
      chk($sformatf("fl2_b%0d_bd", i), bd_b, i == 3 ? 1 : 0);
    end
    chk("fl2_tx_end", tx_b, 10);
    for (int i = 0; i < 256; i++) begin
      int e;
      send(1'b1, i[0]);
      e = (11 + i) % 256;
      if (e == 255) chk("wrap_max", tx_b, 255);
      if (e == 0) chk("wrap_zero", tx_b, 0);
    end
    chk("wrap_tx", tx_b, 10);
    chk("wrap_yv", ib.y_valid, 1);
    send(1'b0, 1'b0);
    chk("end_yv", ib.y_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmux_seq_ctrl.md
# dmux_seq_ctrl

Sequencer that sits directly upstream of the 1-to-4 demultiplexer. It accepts a valid/ready serial bit stream and drives the demux data input `y` and selects `s0`/`s1` from registers. It groups bits into bursts of `BURST` consecutive bits per lane, and chooses lanes either round-robin or by an external directive. A bit reaches exactly one demux output one cycle after it is accepted.

## Interface
- `BURST`, default 4: bits sent to one lane before the lane may change; legal range 1..16.
- `CNT_W`, default 8: width of the transfer counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: run control; low forces IDLE.
- `flush` in 1: synchronous clear of burst position and lane.
- `mode` in 1: 0 = round-robin, 1 = directed.
- `dir_lane` in 2: target lane in directed mode, encoded {s0,s1}.
- `stall` in 1: downstream hold request.
- `in_valid` in 1: input bit present.
- `in_bit` in 1: input data bit.
- `in_ready` out 1: combinational; equals `enable & ~stall & ~flush`.
- `y` out 1: registered data to the demux.
- `s0` out 1: registered select MSB.
- `s1` out 1: registered select LSB.
- `y_valid` out 1: registered; high for the one cycle in which `y` carries an accepted bit.
- `lane_idx` out 2: current lane, equal to {s0,s1}.
- `burst_done` out 1: one-cycle pulse coinciding with the last bit of a burst on `y`.
- `tx_count` out CNT_W: total accepted bits, modulo 2^CNT_W.

## Operation
- Lane encoding matches the demux: {s0,s1} = 00→i0, 01→i1, 10→i2, 11→i3.
- A transfer occurs when `in_valid & in_ready`. On a transfer:
  - `y` ← `in_bit`, {s0,s1} ← active lane, `y_valid` ← 1.
  - `tx_count` increments and wraps to 0 after its maximum value.
  - `beat` increments.
- End of burst, when `beat == BURST-1` on a transfer:
  - `beat` ← 0 and `burst_done` ← 1.
  - Round-robin: the lane advances by 1 modulo 4 (3→0).
- Directed mode: the lane is sampled from `dir_lane` only on a transfer with `beat == 0` and is locked for the rest of the burst.
- A `mode` change takes effect only at a burst boundary (`beat == 0`).
- Round-robin after directed: round-robin resumes from the lane of the last directed burst + 1.
- No transfer and no stall: `y` ← 0 and `y_valid` ← 0, so all demux outputs read 0. `s0`/`s1` hold.
- Stall: `y`, `s0`, `s1` and `y_valid` all hold their values. `in_ready` is 0.
- `flush`: `beat` ← 0, lane ← 0, `y` ← 0, `y_valid` ← 0. `tx_count` is kept. `flush` wins over `stall`.
- `enable` low mid-burst: no transfers occur. `beat` and lane are retained, and the burst resumes on re-enable.
- FSM states:
  - IDLE (`enable` = 0)
  - RUN (`enable` = 1, `stall` = 0)
  - HOLD (`enable` = 1, `stall` = 1)
- FSM transitions:
  - IDLE→RUN on `enable`.
  - RUN↔HOLD on `stall`.
  - Any state→IDLE when `enable` falls.
  - `rst` returns the FSM to IDLE.

## Timing
- Reset values: `y`=0, `s0`=0, `s1`=0, `y_valid`=0, `lane_idx`=0, `burst_done`=0, `tx_count`=0, `beat`=0, state=IDLE. `in_ready`=0 while `rst` or `enable`=0.
- Latency is 1 cycle from accepting a bit to seeing it on `y`/`s0`/`s1`. The downstream demux adds no cycles.
- Throughput is one bit per cycle with no bubble between bursts.
- `burst_done` and `y_valid` are asserted in the same cycle.
- Reset asserted mid-burst clears all state immediately. The first transfer after reset goes to lane 0 with `beat` 0.
- `flush` asserted together with `in_valid`: no transfer occurs, because `in_ready` is 0.

## Structure
- Package `dmux_pkg`:
  - `lane_t` (2-bit),
  - state enum {IDLE, RUN, HOLD},
  - `MODE_RR`/`MODE_DIR` constants,
  - `lane_next()` function (modulo-4 increment).
- Sub-module `dmux_beat_counter`: `BURST`-modulo counter with increment, clear and a wrap flag.
- Top level: FSM, lane register, output registers, `tx_count`.

## Test plan
- Round-robin, `BURST`=2, bits 1,0,1,1,0,0,1,0 back-to-back → {s0,s1} = 00,00,01,01,10,10,11,11. `burst_done` high on bits 2, 4, 6 and 8. The 9th bit goes to lane 00.
- Directed, `dir_lane`=10, `BURST`=4, 4 bits 1,1,0,1 → `s0`=1, `s1`=0 throughout, so only i2 toggles. `dir_lane` changed to 01 mid-burst is ignored until the next burst.
- `stall` asserted after the 2nd bit of a burst for 3 cycles → `in_ready`=0 and outputs frozen. The 3rd bit resumes on the same lane; `tx_count` = 3 after it.
- `rst` pulsed asynchronously mid-burst (lane 01, `beat` 1) → all outputs 0 within the same cycle. The next bit goes to lane 00.
- `flush` on lane 11, `beat` 2 → lane 00, `beat` 0, `y_valid` 0; `tx_count` unchanged.
- `CNT_W`=8: 256 consecutive transfers → `tx_count` wraps 255→0. No transfer is lost.
